// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN output stage: logit/index width helpers and
// the argmax FSM state encoding.
package bnn_pkg;

  function automatic int logit_width(input int width);
    return $clog2(width + 1) + 2;
  endfunction

  function automatic int class_idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam logic ACCUM_ENC = 1'b0;
  localparam logic HOLD_ENC  = 1'b1;

  typedef enum logic {
    ACCUM = ACCUM_ENC,
    HOLD  = HOLD_ENC
  } state_e;

endpackage

// File: rtl/signed_max_select.sv
// Combinational signed compare of a candidate logit against the current best;
// strict greater-than so the earlier (lower) index survives a tie.
module signed_max_select #(
  parameter int LW = 8,
  parameter int IW = 4
) (
  input  logic          load_first,
  input  logic [LW-1:0] cand_val,
  input  logic [IW-1:0] cand_idx,
  input  logic [LW-1:0] best_val,
  input  logic [IW-1:0] best_idx,
  output logic          take,
  output logic [LW-1:0] sel_val,
  output logic [IW-1:0] sel_idx
);

  logic cand_gt;

  assign cand_gt = $signed(cand_val) > $signed(best_val);
  // load_first forces a reload so a previous frame's maximum never leaks in.
  assign take    = load_first | cand_gt;
  assign sel_val = take ? cand_val : best_val;
  assign sel_idx = take ? cand_idx : best_idx;

endmodule

// File: rtl/logit_argmax.sv
// Streaming argmax over NUM_CLASSES signed logits per frame; presents the
// winning class and its logit on a valid/ready output.
//
//   state | meaning
//   ACCUM | accepting logits, tracking running maximum
//   HOLD  | frame complete, result held until out_ready
module logit_argmax
  import bnn_pkg::*;
#(
  parameter int  WIDTH       = 32,
  parameter int  NUM_CLASSES = 10,
  localparam int LW          = logit_width(WIDTH),
  localparam int IW          = class_idx_width(NUM_CLASSES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [LW-1:0] in_logit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_class,
  output logic [LW-1:0] out_logit,
  output logic          busy
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASSES - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] best_val_q, best_val_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_class_q, out_class_d;
  logic [LW-1:0] out_logit_q, out_logit_d;

  logic          accept;
  logic          take;
  logic [LW-1:0] sel_val;
  logic [IW-1:0] sel_idx;

  assign accept = in_valid & in_ready_q;

  signed_max_select #(
    .LW(LW),
    .IW(IW)
  ) u_sel (
    .load_first(idx_q == '0),
    .cand_val  (in_logit),
    .cand_idx  (idx_q),
    .best_val  (best_val_q),
    .best_idx  (best_idx_q),
    .take      (take),
    .sel_val   (sel_val),
    .sel_idx   (sel_idx)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_logit_d = out_logit_q;

    case (state_q)
      ACCUM: begin
        in_ready_d = 1'b1;
        if (accept) begin
          best_val_d = sel_val;
          best_idx_d = sel_idx;
          if (idx_q == LAST_IDX) begin
            // Result registers take the final comparison directly, giving
            // one cycle from the last input handshake to out_valid.
            idx_d       = '0;
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_class_d = sel_idx;
            out_logit_d = sel_val;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      HOLD: begin
        in_ready_d = 1'b0;
        if (out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      idx_q       <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_logit_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_logit_q <= out_logit_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_logit = out_logit_q;
  assign busy      = (idx_q != '0);

  logic unused_take;
  assign unused_take = take;

endmodule

// File: tb/tb_logit_argmax.sv
// Self-checking bench for logit_argmax: directed frame table, reset and
// backpressure sequences, and randomized frames against an argmax model.
module tb_logit_argmax;

  localparam int WIDTH = 32;
  localparam int NC    = 10;
  localparam int LW    = 8;
  localparam int IW    = 4;

  typedef logic signed [LW-1:0] frame_t [NC];
  typedef struct {
    frame_t l;
    int     exp_c;
    int     exp_v;
    int     gap_pct;
    int     hold;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_logit;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_class;
  logic [LW-1:0] out_logit;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logit_argmax #(
    .WIDTH      (WIDTH),
    .NUM_CLASSES(NC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_logit (in_logit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_logit(out_logit),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Argmax as "largest value, then the first position holding it".
  task automatic ref_argmax(input frame_t l, output int c, output int v);
    int mx;
    mx = -100000;
    foreach (l[i]) if (int'(l[i]) > mx) mx = int'(l[i]);
    c = -1;
    foreach (l[i]) if (c < 0 && int'(l[i]) == mx) c = i;
    v = mx;
  endtask

  task automatic mk(input int a[NC], output frame_t f);
    foreach (a[i]) f[i] = LW'(a[i]);
  endtask

  // Sends the first n logits of l; called and returns at a falling edge.
  task automatic send_frame(input frame_t l, input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      int guard;
      bit done;
      guard = 0;
      done  = 1'b0;
      while (!done) begin
        if (gap_pct > 0 && i > 0 && $urandom_range(0, 99) < gap_pct) begin
          in_valid = 1'b0;
          @(negedge clk);
          check("busy_gap", busy, 1);
        end else begin
          in_valid = 1'b1;
          in_logit = l[i];
          if (in_ready) begin
            done = 1'b1;
            if (i == NC - 1) check("out_valid_early", out_valid, 0);
          end
          @(negedge clk);
        end
        guard++;
        if (!done && guard > 100) begin
          check("in_ready_timeout", in_ready, 1);
          done = 1'b1;
        end
      end
      if (i < NC - 1) check("busy_mid", busy, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic frame_done_checks();
    check("latency_out_valid", out_valid, 1);
    check("busy_after_last", busy, 0);
    check("in_ready_hold", in_ready, 0);
  endtask

  task automatic take_result(input int exp_c, input int exp_v, input int hold);
    check("out_class", out_class, exp_c);
    check("out_logit", $signed(out_logit), exp_v);
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      in_logit  = 8'h7f;
      out_ready = 1'b0;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_class", out_class, exp_c);
      check("bp_logit", $signed(out_logit), exp_v);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_out_valid", out_valid, 0);
    check("drop_in_ready", in_ready, 1);
    check("keep_class", out_class, exp_c);
    check("keep_logit", $signed(out_logit), exp_v);
  endtask

  task automatic async_reset_checks(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_class"}, out_class, 0);
    check({tag, "_out_logit"}, $signed(out_logit), 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready_rel"}, in_ready, 1);
  endtask

  vec_t   vt[5];
  int     f_a[NC] = '{-4, 2, 8, -32, 6, 32, 0, 10, -2, 4};
  int     f_b[NC] = '{8, 8, -2, 8, 0, 0, 0, 0, 0, 0};
  int     f_c[NC] = '{-32, -32, -32, -32, -32, -32, -32, -32, -32, -30};
  int     f_d[NC] = '{-10, -12, -8, -8, -32, -20, -14, -16, -18, -30};

  initial begin
    frame_t rf;
    int     rc;
    int     rv;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_logit  = '0;
    out_ready = 1'b0;

    mk(f_a, vt[0].l); vt[0].exp_c = 5; vt[0].exp_v = 32;  vt[0].gap_pct = 0;  vt[0].hold = 0;
    mk(f_b, vt[1].l); vt[1].exp_c = 0; vt[1].exp_v = 8;   vt[1].gap_pct = 0;  vt[1].hold = 0;
    mk(f_c, vt[2].l); vt[2].exp_c = 9; vt[2].exp_v = -30; vt[2].gap_pct = 0;  vt[2].hold = 0;
    mk(f_d, vt[3].l); vt[3].exp_c = 2; vt[3].exp_v = -8;  vt[3].gap_pct = 0;  vt[3].hold = 5;
    mk(f_a, vt[4].l); vt[4].exp_c = 5; vt[4].exp_v = 32;  vt[4].gap_pct = 40; vt[4].hold = 0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_logit", $signed(out_logit), 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready_rel", in_ready, 1);

    for (int k = 0; k < 5; k++) begin
      send_frame(vt[k].l, NC, vt[k].gap_pct);
      frame_done_checks();
      take_result(vt[k].exp_c, vt[k].exp_v, vt[k].hold);
    end

    // Reset after a partial frame, then a full frame must count from idx 0.
    send_frame(vt[0].l, 4, 0);
    async_reset_checks("rst_mid");
    send_frame(vt[3].l, NC, 0);
    frame_done_checks();
    take_result(2, -8, 0);

    // Reset while a result is pending.
    send_frame(vt[0].l, NC, 0);
    frame_done_checks();
    async_reset_checks("rst_hold");
    send_frame(vt[2].l, NC, 0);
    frame_done_checks();
    take_result(9, -30, 0);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NC; i++) begin
        case (r % 3)
          0:       rf[i] = LW'(int'($urandom_range(0, 8)) - 4);
          1:       rf[i] = LW'(int'($urandom_range(0, 2 * WIDTH)) - WIDTH);
          default: rf[i] = LW'($urandom_range(0, 255));
        endcase
      end
      ref_argmax(rf, rc, rv);
      send_frame(rf, NC, (r % 2 == 1) ? 30 : 0);
      frame_done_checks();
      take_result(rc, rv, (r % 4 == 0) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
